// File: rtl/fetch_cache_ctrl.sv
// fetch_cache_ctrl: serves cached-miss line refills and uncached single-word
// fetches for the fetch sequencer. Each request becomes one burst read on the
// memory port. Completion is reported with a one-cycle pulse, and that pulse
// is withheld if the requester dropped its request while the burst was running.
module fetch_cache_ctrl #(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_miss,
  input  logic        req_uncached,
  input  logic [31:0] req_paddr,
  input  logic        req_hit,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  output logic [7:0]  mem_arlen,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_rready,
  output logic        refill_wen,
  output logic [31:0] refill_addr,
  output logic [31:0] refill_data,
  output logic        refill_inv,
  output logic        refill_commit,
  output logic        refilled_hit,
  output logic        uncached_done,
  output logic [31:0] uncached_data
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFF_W = CNT_W + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);
  localparam logic [7:0] LINE_ARLEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, AR, RD, DONE} state_t;

  // Kind of the operation in flight: a full line refill or one uncached word.
  localparam logic KIND_LINE = 1'b0;
  localparam logic KIND_UNC  = 1'b1;

  state_t            state_reg;
  logic              kind_reg;
  logic [31:0]       base_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              abort_reg;
  logic              arvalid_reg;
  logic [31:0]       araddr_reg;
  logic [7:0]        arlen_reg;
  logic              rready_reg;
  logic              inv_reg;
  logic              hit_reg;
  logic              done_reg;
  logic [31:0]       udata_reg;

  logic              beat;
  logic              last_beat;
  logic              req_dropped;
  logic              abort_next;

  // Beat qualification, last-beat detection and abort tracking for the active request.
  always_comb begin
    beat        = (state_reg == RD) && mem_rvalid;
    last_beat   = (kind_reg == KIND_UNC) || (cnt_reg == LAST_CNT);
    req_dropped = (kind_reg == KIND_UNC) ? !req_uncached : !req_miss;
    abort_next  = abort_reg || req_dropped;
  end

  // Cache array write port: driven in the same cycle as each line beat, and
  // carrying the line base during the invalidate pulse; zero otherwise.
  always_comb begin
    refill_wen    = beat && (kind_reg == KIND_LINE);
    refill_commit = refill_wen && last_beat;
    refill_inv    = inv_reg;
    refill_data   = 32'd0;
    refill_addr   = 32'd0;
    if (refill_wen) begin
      refill_addr = base_reg + {{(30 - CNT_W){1'b0}}, cnt_reg, 2'b00};
      refill_data = mem_rdata;
    end else if (inv_reg) begin
      refill_addr = base_reg;
    end
  end

  assign mem_arvalid   = arvalid_reg;
  assign mem_araddr    = araddr_reg;
  assign mem_arlen     = arlen_reg;
  assign mem_rready    = rready_reg;
  assign refilled_hit  = hit_reg;
  assign uncached_done = done_reg;
  assign uncached_data = udata_reg;

  // Request FSM: registered launch from IDLE, address phase, data drain, one-cycle completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      kind_reg    <= KIND_LINE;
      base_reg    <= 32'd0;
      cnt_reg     <= '0;
      abort_reg   <= 1'b0;
      arvalid_reg <= 1'b0;
      araddr_reg  <= 32'd0;
      arlen_reg   <= 8'd0;
      rready_reg  <= 1'b0;
      inv_reg     <= 1'b0;
      hit_reg     <= 1'b0;
      done_reg    <= 1'b0;
      udata_reg   <= 32'd0;
    end else begin
      inv_reg  <= 1'b0;
      hit_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          abort_reg <= 1'b0;
          if (req_uncached) begin
            kind_reg    <= KIND_UNC;
            base_reg    <= req_paddr & ~32'd3;
            araddr_reg  <= req_paddr & ~32'd3;
            arlen_reg   <= 8'd0;
            arvalid_reg <= 1'b1;
            state_reg   <= AR;
          end else if (req_miss && !req_hit) begin
            kind_reg    <= KIND_LINE;
            base_reg    <= req_paddr & LINE_MASK;
            araddr_reg  <= req_paddr & LINE_MASK;
            arlen_reg   <= LINE_ARLEN;
            arvalid_reg <= 1'b1;
            inv_reg     <= 1'b1;
            state_reg   <= AR;
          end
        end
        AR: begin
          abort_reg <= abort_next;
          if (mem_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= RD;
          end
        end
        RD: begin
          abort_reg <= abort_next;
          if (mem_rvalid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (kind_reg == KIND_UNC) begin
              udata_reg <= mem_rdata;
            end
            if (last_beat) begin
              rready_reg <= 1'b0;
              state_reg  <= DONE;
              if (!abort_next) begin
                hit_reg  <= (kind_reg == KIND_LINE);
                done_reg <= (kind_reg == KIND_UNC);
              end
            end
          end
        end
        DONE: begin
          abort_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_cache_ctrl.sv
// Scoreboard bench for fetch_cache_ctrl: the stimulus pushes expected memory
// requests, cache writes and completion pulses into queues, and a monitor pops
// and compares them whenever the DUT presents the corresponding output.
module tb_fetch_cache_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_miss;
  logic        req_uncached;
  logic [31:0] req_paddr;
  logic        req_hit;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        refill_wen;
  logic [31:0] refill_addr;
  logic [31:0] refill_data;
  logic        refill_inv;
  logic        refill_commit;
  logic        refilled_hit;
  logic        uncached_done;
  logic [31:0] uncached_data;

  fetch_cache_ctrl #(.LINE_WORDS(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_miss(req_miss), .req_uncached(req_uncached),
    .req_paddr(req_paddr), .req_hit(req_hit),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rready(mem_rready),
    .refill_wen(refill_wen), .refill_addr(refill_addr), .refill_data(refill_data),
    .refill_inv(refill_inv), .refill_commit(refill_commit),
    .refilled_hit(refilled_hit), .uncached_done(uncached_done),
    .uncached_data(uncached_data)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

  ar_t         ar_q[$];
  logic [31:0] inv_q[$];
  wr_t         wr_q[$];
  logic [31:0] commit_q[$];
  logic [31:0] done_q[$];
  int          hit_pending = 0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int commit_cyc = -10;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] v);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event value %h expected none (cycle %0d)", name, v, cyc);
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard queues.
  initial begin : monitor
    logic        arv_prev;
    logic [31:0] ar_hold;
    ar_t         a;
    wr_t         w;
    logic [31:0] e;
    arv_prev = 1'b0;
    ar_hold  = 32'd0;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        if (mem_arvalid === 1'b1 && arv_prev !== 1'b1) begin
          if (ar_q.size() == 0) unexpected("ar_issue", mem_araddr);
          else begin
            a = ar_q.pop_front();
            chk("araddr", mem_araddr, a.addr);
            chk("arlen", {24'd0, mem_arlen}, {24'd0, a.len});
          end
          ar_hold = mem_araddr;
        end else if (mem_arvalid === 1'b1) begin
          chk("araddr_stable", mem_araddr, ar_hold);
        end
        if (refill_inv === 1'b1) begin
          if (inv_q.size() == 0) unexpected("refill_inv", refill_addr);
          else begin
            e = inv_q.pop_front();
            chk("inv_addr", refill_addr, e);
          end
        end
        if (refill_wen === 1'b1) begin
          if (wr_q.size() == 0) unexpected("refill_wen", refill_addr);
          else begin
            w = wr_q.pop_front();
            chk("wen_addr", refill_addr, w.addr);
            chk("wen_data", refill_data, w.data);
          end
        end
        if (refill_commit === 1'b1) begin
          commit_cyc = cyc;
          if (commit_q.size() == 0) unexpected("refill_commit", refill_addr);
          else begin
            e = commit_q.pop_front();
            chk("commit_addr", refill_addr, e);
          end
        end
        if (refilled_hit === 1'b1) begin
          if (hit_pending == 0) unexpected("refilled_hit", 32'd1);
          else begin
            hit_pending--;
            chk("hit_after_commit", 32'(cyc), 32'(commit_cyc + 1));
          end
        end
        if (uncached_done === 1'b1) begin
          if (done_q.size() == 0) unexpected("uncached_done", uncached_data);
          else begin
            e = done_q.pop_front();
            chk("uncached_data", uncached_data, e);
          end
        end
      end
      arv_prev = mem_arvalid;
    end
  end

  task automatic expect_line(input logic [31:0] base, input logic [31:0] d0, input bit with_hit);
    ar_q.push_back('{addr: base, len: 8'd7});
    inv_q.push_back(base);
    for (int i = 0; i < 8; i++) wr_q.push_back('{addr: base + 32'(4 * i), data: d0 + 32'(i)});
    commit_q.push_back(base + 32'h1C);
    if (with_hit) hit_pending++;
  endtask

  task automatic expect_unc(input logic [31:0] addr, input logic [31:0] data);
    ar_q.push_back('{addr: addr, len: 8'd0});
    done_q.push_back(data);
  endtask

  // Memory responder: waits (bounded) for the address phase, accepts it after
  // ar_delay cycles, then returns beats, optionally with gaps and a request drop.
  task automatic serve(input int beats, input logic [31:0] d0, input int ar_delay,
                       input bit gaps, input int drop_after, output int waited);
    waited = 0;
    while (mem_arvalid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (mem_arvalid !== 1'b1) begin
      unexpected("ar_timeout", 32'(waited));
      return;
    end
    repeat (ar_delay) begin @(posedge clk); #1; end
    mem_arready = 1'b1;
    @(posedge clk); #1;
    mem_arready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      if (gaps && (i % 2 == 1)) begin
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = d0 + 32'(i);
      @(posedge clk); #1;
      if (i + 1 == drop_after) req_miss = 1'b0;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_arvalid"}, {31'd0, mem_arvalid}, 32'd0);
    chk({tag, "_araddr"}, mem_araddr, 32'd0);
    chk({tag, "_arlen"}, {24'd0, mem_arlen}, 32'd0);
    chk({tag, "_rready"}, {31'd0, mem_rready}, 32'd0);
    chk({tag, "_wen"}, {31'd0, refill_wen}, 32'd0);
    chk({tag, "_raddr"}, refill_addr, 32'd0);
    chk({tag, "_rdata"}, refill_data, 32'd0);
    chk({tag, "_inv"}, {31'd0, refill_inv}, 32'd0);
    chk({tag, "_commit"}, {31'd0, refill_commit}, 32'd0);
    chk({tag, "_hit"}, {31'd0, refilled_hit}, 32'd0);
    chk({tag, "_done"}, {31'd0, uncached_done}, 32'd0);
    chk({tag, "_udata"}, uncached_data, 32'd0);
  endtask

  initial begin : stimulus
    int w;
    resetn = 1'b0; req_miss = 1'b0; req_uncached = 1'b0; req_paddr = 32'd0; req_hit = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Cached miss: line base 0x1000_0000, data A0..A7.
    expect_line(32'h1000_0000, 32'hA0, 1'b1);
    req_paddr = 32'h1000_0014; req_miss = 1'b1; req_hit = 1'b0;
    serve(8, 32'hA0, 0, 1'b0, 0, w);
    chk("miss_launch_latency", 32'(w), 32'd1);
    req_miss = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Uncached word.
    expect_unc(32'h1FC0_0004, 32'hDEADBEEF);
    req_paddr = 32'h1FC0_0006; req_uncached = 1'b1;
    serve(1, 32'hDEADBEEF, 0, 1'b0, 0, w);
    req_uncached = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Uncached held across the done pulse: immediate restart to the same word.
    expect_unc(32'h1FC0_0010, 32'h1111_1111);
    expect_unc(32'h1FC0_0010, 32'h2222_2222);
    req_paddr = 32'h1FC0_0012; req_uncached = 1'b1;
    serve(1, 32'h1111_1111, 0, 1'b0, 0, w);
    serve(1, 32'h2222_2222, 0, 1'b0, 0, w);
    chk("unc_restart_gap", 32'(w), 32'd2);
    req_uncached = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Hit gates the miss; then uncached wins over a simultaneous miss.
    req_paddr = 32'h1000_0020; req_miss = 1'b1; req_hit = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("hit_gate_arvalid", {31'd0, mem_arvalid}, 32'd0);
    req_hit = 1'b0;
    expect_unc(32'h1000_0020, 32'h5A5A_5A5A);
    req_uncached = 1'b1;
    serve(1, 32'h5A5A_5A5A, 0, 1'b0, 0, w);
    req_uncached = 1'b0; req_miss = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Abort: miss dropped after beat 3, gaps in the data; writes and commit still happen.
    expect_line(32'h1000_0040, 32'h100, 1'b0);
    req_paddr = 32'h1000_0048; req_miss = 1'b1;
    serve(8, 32'h100, 0, 1'b1, 3, w);
    repeat (5) @(posedge clk);
    #1;

    // Next miss served normally, with a delayed address acceptance.
    expect_line(32'h1000_0100, 32'hC0, 1'b1);
    req_paddr = 32'h1000_011C; req_miss = 1'b1;
    serve(8, 32'hC0, 2, 1'b0, 0, w);
    req_miss = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of the data phase after 4 beats.
    ar_q.push_back('{addr: 32'h2000_0040, len: 8'd7});
    inv_q.push_back(32'h2000_0040);
    for (int i = 0; i < 4; i++) wr_q.push_back('{addr: 32'h2000_0040 + 32'(4 * i), data: 32'hE0 + 32'(i)});
    req_paddr = 32'h2000_0044; req_miss = 1'b1;
    serve(4, 32'hE0, 0, 1'b0, 0, w);
    resetn = 1'b0; req_miss = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    resetn = 1'b1;
    @(posedge clk); #1;

    // A fresh request after the reset completes normally.
    expect_line(32'h3000_0000, 32'hF0, 1'b1);
    req_paddr = 32'h3000_0004; req_miss = 1'b1;
    serve(8, 32'hF0, 0, 1'b0, 0, w);
    req_miss = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    chk("left_ar", 32'(ar_q.size()), 32'd0);
    chk("left_inv", 32'(inv_q.size()), 32'd0);
    chk("left_wen", 32'(wr_q.size()), 32'd0);
    chk("left_commit", 32'(commit_q.size()), 32'd0);
    chk("left_hit", 32'(hit_pending), 32'd0);
    chk("left_done", 32'(done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
